// File: rtl/onchip_mem_copy_master_pkg.sv
// Shared types and constants for the on-chip memory copy master.
// The state encoding and bus constants are shared by the interface, the top and the bench.
package onchip_mem_copy_pkg;

   localparam int          DATA_W = 32;
   localparam logic [3:0]  BE_ALL = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      WRITE,
      DONE
   } copy_state_e;

endpackage

// File: rtl/onchip_mem_copy_master_if.sv
// Control and Avalon-MM bundle for onchip_mem_copy_master.
// The master modport is the copy engine side; the slave modport is software plus memory.
interface onchip_mem_copy_master_if
   import onchip_mem_copy_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int LEN_W  = 14
);

   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] checksum;

   logic [ADDR_W-1:0] m_address;
   logic [3:0]        m_byteenable;
   logic              m_chipselect;
   logic              m_write;
   logic [DATA_W-1:0] m_writedata;
   logic              m_clken;
   logic [DATA_W-1:0] m_readdata;

   modport master (
      input  start, abort, src_addr, dst_addr, len, m_readdata,
      output busy, done, checksum,
             m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
   );

   modport slave (
      output start, abort, src_addr, dst_addr, len, m_readdata,
      input  busy, done, checksum,
             m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
   );

endinterface

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master copying a block of 32-bit words inside a single-port on-chip memory.
// Optional feature macro: COPY_CHECKSUM_EN adds a wrapping sum of all words read.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// READ    | one-cycle read strobe at src+idx, latency counter loaded
// CAPTURE | wait READ_LATENCY cycles, capture readdata on the last one
// WRITE   | one-cycle write strobe at dst+idx with captured word
// DONE    | one-cycle done pulse, then back to IDLE
module onchip_mem_copy_master
   import onchip_mem_copy_pkg::*;
#(
   parameter int ADDR_W       = 14,
   parameter int LEN_W        = 14,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   onchip_mem_copy_master_if.master bus
);

   copy_state_e       r_state;
   copy_state_e       w_state_next;

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W-1:0] r_address;
   logic [ADDR_W-1:0] w_src_base;
   logic [ADDR_W-1:0] w_addr_next;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_idx;
   logic [LEN_W-1:0]  w_idx_next;
   logic [2:0]        r_lat;
   logic [DATA_W-1:0] r_data;
   logic              r_cs;
   logic              r_we;
   logic              r_busy;
   logic              r_done;
   logic              w_accept;
   logic              w_capture;
   logic              w_last;

   // Compare one bit wider so idx+1 cannot wrap on a maximum-length block.
   assign w_last = ({1'b0, r_idx} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, r_len};

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               w_accept     = 1'b1;
               w_idx_next   = '0;
               w_state_next = (bus.len == '0) ? DONE : READ;
            end
         end
         READ: begin
            w_state_next = bus.abort ? IDLE : CAPTURE;
         end
         CAPTURE: begin
            if (bus.abort) begin
               w_state_next = IDLE;
            end else if (r_lat == 3'd1) begin
               w_capture    = 1'b1;
               w_state_next = WRITE;
            end
         end
         WRITE: begin
            w_idx_next = r_idx + LEN_W'(1);
            if (bus.abort) begin
               w_state_next = IDLE;
            end else if (w_last) begin
               w_state_next = DONE;
            end else begin
               w_state_next = READ;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      // On the accepting cycle the source base is not latched yet.
      w_src_base  = w_accept ? bus.src_addr : r_src;
      w_addr_next = r_address;
      if (w_state_next == READ) begin
         w_addr_next = w_src_base + ADDR_W'(w_idx_next);
      end else if (w_state_next == WRITE) begin
         w_addr_next = r_dst + ADDR_W'(r_idx);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_idx     <= '0;
         r_lat     <= '0;
         r_data    <= '0;
         r_address <= '0;
         r_cs      <= 1'b0;
         r_we      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_idx     <= w_idx_next;
         r_address <= w_addr_next;
         if (w_accept) begin
            r_src <= bus.src_addr;
            r_dst <= bus.dst_addr;
            r_len <= bus.len;
         end
         if (w_state_next == READ) begin
            r_lat <= 3'(READ_LATENCY);
         end else if (r_state == CAPTURE) begin
            r_lat <= r_lat - 3'd1;
         end
         if (w_capture) begin
            r_data <= bus.m_readdata;
         end
         r_cs   <= (w_state_next == READ) || (w_state_next == WRITE);
         r_we   <= (w_state_next == WRITE);
         r_busy <= (w_state_next == READ) || (w_state_next == CAPTURE) ||
                   (w_state_next == WRITE);
         r_done <= (w_state_next == DONE);
      end
   end

`ifdef COPY_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= '0;
      end else if (w_capture) begin
         r_checksum <= r_checksum + bus.m_readdata;
      end
   end

   assign bus.checksum = r_checksum;
`else
   assign bus.checksum = '0;
`endif

   assign bus.m_address    = r_address;
   assign bus.m_byteenable = BE_ALL;
   assign bus.m_chipselect = r_cs;
   assign bus.m_write      = r_we;
   assign bus.m_writedata  = r_data;
   assign bus.m_clken      = 1'b1;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Directed bench for onchip_mem_copy_master: latency-1 and latency-3 instances,
// each with its own behavioural on-chip memory.
module tb_onchip_mem_copy_master;
   import onchip_mem_copy_pkg::*;

   localparam int AW = 14;
   localparam int LW = 14;
`ifdef COPY_CHECKSUM_EN
   localparam bit CKS_EN = 1'b1;
`else
   localparam bit CKS_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   int   cyc = 0;
   int   cs1 = 0;
   int   rp1 = 0;
   int   wp1 = 0;
   int   dn1 = 0;
   logic [13:0] rlog1 [64];
   logic [13:0] wlog1 [64];

   logic [31:0] mem1 [16384];
   logic [31:0] mem3 [16384];
   logic [31:0] rd1;
   logic [31:0] p3 [3];

   logic        pl_we   = 1'b0;
   logic        pl_sel  = 1'b0;
   logic [13:0] pl_addr = '0;
   logic [31:0] pl_data = '0;

   always #5 clk = ~clk;

   onchip_mem_copy_master_if #(.ADDR_W(AW), .LEN_W(LW)) bus1 ();
   onchip_mem_copy_master_if #(.ADDR_W(AW), .LEN_W(LW)) bus3 ();

   onchip_mem_copy_master #(.ADDR_W(AW), .LEN_W(LW), .READ_LATENCY(1)) u_dut1 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus1)
   );

   onchip_mem_copy_master #(.ADDR_W(AW), .LEN_W(LW), .READ_LATENCY(3)) u_dut3 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus3)
   );

   assign bus1.m_readdata = rd1;
   assign bus3.m_readdata = p3[2];

   // Memories return a poison word when not read, so a mistimed capture shows up.
   always @(posedge clk) begin
      if (pl_we && !pl_sel) mem1[pl_addr] <= pl_data;
      else if (bus1.m_chipselect && bus1.m_write) mem1[bus1.m_address] <= bus1.m_writedata;
      rd1 <= (bus1.m_chipselect && !bus1.m_write) ? mem1[bus1.m_address] : 32'hBAD0_BAD0;
   end

   always @(posedge clk) begin
      if (pl_we && pl_sel) mem3[pl_addr] <= pl_data;
      else if (bus3.m_chipselect && bus3.m_write) mem3[bus3.m_address] <= bus3.m_writedata;
      p3[0] <= (bus3.m_chipselect && !bus3.m_write) ? mem3[bus3.m_address] : 32'hBAD0_BAD0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus1.done) dn1 <= dn1 + 1;
      if (bus1.m_chipselect) begin
         cs1 <= cs1 + 1;
         if (bus1.m_write) begin
            wlog1[wp1 % 64] <= bus1.m_address;
            wp1 <= wp1 + 1;
         end else begin
            rlog1[rp1 % 64] <= bus1.m_address;
            rp1 <= rp1 + 1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic poke(input logic sel, input logic [13:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_sel  = sel;
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(negedge clk);
      pl_we   = 1'b0;
   endtask

   // Runs one copy on the latency-1 instance; k counts cycles after the accepting edge.
   task automatic do_copy1(input logic [13:0] src, input logic [13:0] dst, input logic [13:0] len,
                           input int glitch_at, input int abort_at,
                           output int lat, output bit busy_seen, output logic busy_done,
                           output logic busy_after, output logic [31:0] cks);
      lat        = -1;
      busy_seen  = 1'b0;
      busy_done  = 1'bx;
      busy_after = 1'bx;
      cks        = 'x;
      @(negedge clk);
      bus1.src_addr = src;
      bus1.dst_addr = dst;
      bus1.len      = len;
      bus1.start    = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         bus1.start = (k == glitch_at);
         if (k == glitch_at) begin
            bus1.src_addr = src + 14'h200;
            bus1.dst_addr = dst + 14'h200;
            bus1.len      = len + 14'd2;
         end
         bus1.abort = (k == abort_at);
         if (abort_at >= 0 && k == abort_at + 1) busy_after = bus1.busy;
         if (bus1.busy) busy_seen = 1'b1;
         if (bus1.done && lat < 0) begin
            lat       = k;
            busy_done = bus1.busy;
            cks       = bus1.checksum;
         end
         if (lat >= 0 && k >= lat + 3) break;
      end
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
      n_cmp++; if (bus1.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus1.done); end
      n_cmp++; if (bus1.checksum !== 32'h0) begin n_err++; $display("FAIL reset_checksum: got %h want 0", bus1.checksum); end
      n_cmp++; if (bus1.m_chipselect !== 1'b0) begin n_err++; $display("FAIL reset_cs: got %b want 0", bus1.m_chipselect); end
      n_cmp++; if (bus1.m_write !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b want 0", bus1.m_write); end
      n_cmp++; if (bus1.m_address !== 14'h0) begin n_err++; $display("FAIL reset_address: got %h want 0", bus1.m_address); end
      n_cmp++; if (bus1.m_writedata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", bus1.m_writedata); end
      n_cmp++; if (bus1.m_byteenable !== 4'hF) begin n_err++; $display("FAIL reset_be: got %h want f", bus1.m_byteenable); end
      n_cmp++; if (bus1.m_clken !== 1'b1) begin n_err++; $display("FAIL reset_clken: got %b want 1", bus1.m_clken); end
      n_cmp++; if (bus3.busy !== 1'b0 || bus3.m_chipselect !== 1'b0) begin
         n_err++; $display("FAIL reset_dut3: got busy=%b cs=%b want 0 0", bus3.busy, bus3.m_chipselect);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus1.busy !== 1'b0 || bus1.m_chipselect !== 1'b0) begin
         n_err++; $display("FAIL idle_after_reset: got busy=%b cs=%b want 0 0", bus1.busy, bus1.m_chipselect);
      end
   endtask

   task automatic test_basic;
      logic [31:0] src_w [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      int lat; bit bs; logic bd, ba; logic [31:0] cks;
      int c0, r0, w0, d0;
      for (int i = 0; i < 4; i++) poke(1'b0, 14'h010 + 14'(i), src_w[i]);
      for (int i = 0; i < 5; i++) poke(1'b0, 14'h100 + 14'(i), 32'hDEAD_0000 + 32'(i));
      c0 = cs1; r0 = rp1; w0 = wp1; d0 = dn1;
      do_copy1(14'h010, 14'h100, 14'd4, -1, -1, lat, bs, bd, ba, cks);
      n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL basic_done_latency: got %0d want 12", lat); end
      n_cmp++; if (bs !== 1'b1) begin n_err++; $display("FAIL basic_busy_seen: got %b want 1", bs); end
      n_cmp++; if (bd !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b want 0", bd); end
      n_cmp++; if (cks !== (CKS_EN ? 32'hAA : 32'h0)) begin n_err++; $display("FAIL basic_checksum: got %h want %h", cks, CKS_EN ? 32'hAA : 32'h0); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (mem1[14'h100 + 14'(i)] !== src_w[i]) begin n_err++; $display("FAIL basic_dst[%0d]: got %h want %h", i, mem1[14'h100 + 14'(i)], src_w[i]); end
         n_cmp++; if (rlog1[(r0 + i) % 64] !== 14'h010 + 14'(i)) begin n_err++; $display("FAIL basic_raddr[%0d]: got %h want %h", i, rlog1[(r0 + i) % 64], 14'h010 + 14'(i)); end
         n_cmp++; if (wlog1[(w0 + i) % 64] !== 14'h100 + 14'(i)) begin n_err++; $display("FAIL basic_waddr[%0d]: got %h want %h", i, wlog1[(w0 + i) % 64], 14'h100 + 14'(i)); end
      end
      n_cmp++; if (mem1[14'h104] !== 32'hDEAD_0004) begin n_err++; $display("FAIL basic_overrun: got %h want dead0004", mem1[14'h104]); end
      n_cmp++; if (cs1 - c0 !== 8) begin n_err++; $display("FAIL basic_bus_cycles: got %0d want 8", cs1 - c0); end
      n_cmp++; if (dn1 - d0 !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", dn1 - d0); end
   endtask

   task automatic test_zero_len;
      int lat; bit bs; logic bd, ba; logic [31:0] cks;
      int c0, d0;
      c0 = cs1; d0 = dn1;
      do_copy1(14'h055, 14'h066, 14'd0, -1, -1, lat, bs, bd, ba, cks);
      n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL zero_done_latency: got %0d want 0", lat); end
      n_cmp++; if (bs !== 1'b0) begin n_err++; $display("FAIL zero_busy_seen: got %b want 0", bs); end
      n_cmp++; if (cks !== 32'h0) begin n_err++; $display("FAIL zero_checksum_cleared: got %h want 0", cks); end
      n_cmp++; if (cs1 - c0 !== 0) begin n_err++; $display("FAIL zero_bus_cycles: got %0d want 0", cs1 - c0); end
      n_cmp++; if (dn1 - d0 !== 1) begin n_err++; $display("FAIL zero_done_count: got %0d want 1", dn1 - d0); end
   endtask

   task automatic test_wrap;
      logic [13:0] exp_r [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
      logic [31:0] exp_d [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
      int lat; bit bs; logic bd, ba; logic [31:0] cks;
      int r0, w0;
      poke(1'b0, 14'h3FFE, 32'h100);
      poke(1'b0, 14'h3FFF, 32'h200);
      poke(1'b0, 14'h0000, 32'hEEEE_0000);
      poke(1'b0, 14'h0001, 32'hEEEE_0001);
      poke(1'b0, 14'h0004, 32'hEEEE_0004);
      r0 = rp1; w0 = wp1;
      do_copy1(14'h3FFE, 14'h0000, 14'd4, -1, -1, lat, bs, bd, ba, cks);
      n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL wrap_done_latency: got %0d want 12", lat); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rlog1[(r0 + i) % 64] !== exp_r[i]) begin n_err++; $display("FAIL wrap_raddr[%0d]: got %h want %h", i, rlog1[(r0 + i) % 64], exp_r[i]); end
         n_cmp++; if (wlog1[(w0 + i) % 64] !== 14'(i)) begin n_err++; $display("FAIL wrap_waddr[%0d]: got %h want %h", i, wlog1[(w0 + i) % 64], 14'(i)); end
         n_cmp++; if (mem1[14'(i)] !== exp_d[i]) begin n_err++; $display("FAIL wrap_dst[%0d]: got %h want %h", i, mem1[14'(i)], exp_d[i]); end
      end
      n_cmp++; if (mem1[14'h0004] !== 32'hEEEE_0004) begin n_err++; $display("FAIL wrap_overrun: got %h want eeee0004", mem1[14'h0004]); end
      n_cmp++; if (cks !== (CKS_EN ? 32'h600 : 32'h0)) begin n_err++; $display("FAIL wrap_checksum: got %h want %h", cks, CKS_EN ? 32'h600 : 32'h0); end
   endtask

   task automatic test_abort;
      int lat; bit bs; logic bd, ba; logic [31:0] cks;
      int w0, d0;
      poke(1'b0, 14'h200, 32'hC0DE_0000);
      poke(1'b0, 14'h201, 32'hC0DE_0001);
      poke(1'b0, 14'h300, 32'h5EED_0000);
      poke(1'b0, 14'h301, 32'h5EED_0001);
      poke(1'b0, 14'h312, 32'h5EED_0312);
      w0 = wp1; d0 = dn1;
      do_copy1(14'h200, 14'h300, 14'd8, -1, 4, lat, bs, bd, ba, cks);
      n_cmp++; if (lat !== -1) begin n_err++; $display("FAIL abort_no_done: got done at %0d want none", lat); end
      n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL abort_busy_next: got %b want 0", ba); end
      n_cmp++; if (dn1 - d0 !== 0) begin n_err++; $display("FAIL abort_done_count: got %0d want 0", dn1 - d0); end
      n_cmp++; if (wp1 - w0 !== 1) begin n_err++; $display("FAIL abort_writes: got %0d want 1", wp1 - w0); end
      n_cmp++; if (mem1[14'h300] !== 32'hC0DE_0000) begin n_err++; $display("FAIL abort_word0: got %h want c0de0000", mem1[14'h300]); end
      n_cmp++; if (mem1[14'h301] !== 32'h5EED_0001) begin n_err++; $display("FAIL abort_word1: got %h want 5eed0001", mem1[14'h301]); end
      do_copy1(14'h200, 14'h310, 14'd2, -1, -1, lat, bs, bd, ba, cks);
      n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL restart_done_latency: got %0d want 6", lat); end
      n_cmp++; if (mem1[14'h310] !== 32'hC0DE_0000 || mem1[14'h311] !== 32'hC0DE_0001) begin
         n_err++; $display("FAIL restart_dst: got %h %h want c0de0000 c0de0001", mem1[14'h310], mem1[14'h311]);
      end
      n_cmp++; if (mem1[14'h312] !== 32'h5EED_0312) begin n_err++; $display("FAIL restart_overrun: got %h want 5eed0312", mem1[14'h312]); end
      n_cmp++; if (cks !== (CKS_EN ? 32'h81BC_0001 : 32'h0)) begin n_err++; $display("FAIL restart_checksum: got %h want %h", cks, CKS_EN ? 32'h81BC_0001 : 32'h0); end
   endtask

   task automatic test_back_to_back;
      int lat; bit bs; logic bd, ba; logic [31:0] cks;
      int r0, w0, d0;
      for (int i = 0; i < 3; i++) poke(1'b0, 14'h400 + 14'(i), 32'hA0 + 32'(i));
      poke(1'b0, 14'h503, 32'h5EED_0503);
      poke(1'b0, 14'h700, 32'h5EED_0700);
      r0 = rp1; w0 = wp1; d0 = dn1;
      do_copy1(14'h400, 14'h500, 14'd3, 2, -1, lat, bs, bd, ba, cks);
      n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL b2b_done_latency: got %0d want 9", lat); end
      n_cmp++; if (dn1 - d0 !== 1) begin n_err++; $display("FAIL b2b_done_count: got %0d want 1", dn1 - d0); end
      n_cmp++; if (wp1 - w0 !== 3 || rp1 - r0 !== 3) begin
         n_err++; $display("FAIL b2b_access_count: got w=%0d r=%0d want 3 3", wp1 - w0, rp1 - r0);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rlog1[(r0 + i) % 64] !== 14'h400 + 14'(i) || wlog1[(w0 + i) % 64] !== 14'h500 + 14'(i)) begin
            n_err++; $display("FAIL b2b_addr[%0d]: got r=%h w=%h want %h %h", i, rlog1[(r0 + i) % 64], wlog1[(w0 + i) % 64], 14'h400 + 14'(i), 14'h500 + 14'(i));
         end
         n_cmp++; if (mem1[14'h500 + 14'(i)] !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL b2b_dst[%0d]: got %h want %h", i, mem1[14'h500 + 14'(i)], 32'hA0 + 32'(i)); end
      end
      n_cmp++; if (mem1[14'h503] !== 32'h5EED_0503 || mem1[14'h700] !== 32'h5EED_0700) begin
         n_err++; $display("FAIL b2b_untouched: got %h %h want 5eed0503 5eed0700", mem1[14'h503], mem1[14'h700]);
      end
   endtask

   task automatic test_latency3;
      int lat = -1;
      logic bd = 1'bx;
      logic [31:0] cks = 'x;
      poke(1'b1, 14'h020, 32'hFFFF_FFFF);
      poke(1'b1, 14'h021, 32'hFFFF_FFFF);
      poke(1'b1, 14'h040, 32'h1234_0040);
      poke(1'b1, 14'h041, 32'h1234_0041);
      poke(1'b1, 14'h042, 32'h1234_0042);
      @(negedge clk);
      bus3.src_addr = 14'h020;
      bus3.dst_addr = 14'h040;
      bus3.len      = 14'd2;
      bus3.start    = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         bus3.start = 1'b0;
         if (bus3.done) begin
            lat = k;
            bd  = bus3.busy;
            cks = bus3.checksum;
            break;
         end
      end
      @(negedge clk);
      n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL lat3_done_latency: got %0d want 10", lat); end
      n_cmp++; if (bd !== 1'b0) begin n_err++; $display("FAIL lat3_busy_at_done: got %b want 0", bd); end
      n_cmp++; if (mem3[14'h040] !== 32'hFFFF_FFFF || mem3[14'h041] !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL lat3_dst: got %h %h want ffffffff ffffffff", mem3[14'h040], mem3[14'h041]);
      end
      n_cmp++; if (mem3[14'h042] !== 32'h1234_0042) begin n_err++; $display("FAIL lat3_overrun: got %h want 12340042", mem3[14'h042]); end
      n_cmp++; if (cks !== (CKS_EN ? 32'hFFFF_FFFE : 32'h0)) begin n_err++; $display("FAIL lat3_checksum: got %h want %h", cks, CKS_EN ? 32'hFFFF_FFFE : 32'h0); end
   endtask

   initial begin
      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.src_addr = '0; bus1.dst_addr = '0; bus1.len = '0;
      bus3.start = 1'b0; bus3.abort = 1'b0; bus3.src_addr = '0; bus3.dst_addr = '0; bus3.len = '0;
      test_reset();
      test_basic();
      test_zero_len();
      test_wrap();
      test_abort();
      test_back_to_back();
      test_latency3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
